id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 stall_i  in  1  hold current contents.
REQ-005 flush_i  in  1  load bubble instead of incoming instruction.
REQ-006 RS1data_i, RS2data_i  in  DATA_W  register-file read data.
REQ-007 imm_i  in  DATA_W  sign-extended immediate.
REQ-008 ALUSrc_i  in  1  1 selects immediate as second operand.
REQ-009 ALUCtrl_i  in  3  ALU operation code, passed through.
REQ-010 ctrl_i  in  4  {RegWrite, MemtoReg, MemRead, MemWrite}.
REQ-011 RS1addr_i, RS2addr_i, RDaddr_i  in  5  register indices.
REQ-012 EXMEM_RegWrite_i  in  1, EXMEM_RDaddr_i  in  5, EXMEM_data_i  in  DATA_W  forward source 1.
REQ-013 MEMWB_RegWrite_i  in  1, MEMWB_RDaddr_i  in  5, MEMWB_data_i  in  DATA_W  forward source 2.
REQ-014 data1_o, data2_o  out  DATA_W  ALU operands.
REQ-015 store_data_o  out  DATA_W  forwarded rs2 value for stores.
REQ-016 ALUCtrl_o  out  3; ctrl_o  out  4; RDaddr_o, RS1addr_o, RS2addr_o  out  5; valid_o  out  1.

Function
REQ-017 Registered fields: RS1data, RS2data, imm, ALUSrc, ALUCtrl, ctrl, RS1addr, RS2addr, RDaddr, valid; latency one cycle input-to-register.
REQ-018 Per edge, priority rst_i > flush_i > stall_i > load.
REQ-019 Load: all fields take inputs, valid=1.
REQ-020 Stall: all fields hold; valid holds.
REQ-021 Flush (including flush_i and stall_i together): ctrl=0, valid=0, RDaddr=0; data fields don't-care but driven to 0.
REQ-022 Forward select A: EX/MEM if EXMEM_RegWrite_i and EXMEM_RDaddr_i!=0 and equals registered RS1addr; else MEM/WB under same rule; else registered RS1data. Select B identically for RS2.
REQ-023 Both sources match: EX/MEM wins.
REQ-024 Index 0 never forwarded; operand is registered data.
REQ-025 Forwarding is combinational from current register contents and forward inputs; during stall, outputs follow changing forward inputs.
REQ-026 data1_o = forwarded A; store_data_o = forwarded B; data2_o = imm when registered ALUSrc=1, else forwarded B.
REQ-027 ALUCtrl_o, ctrl_o, address outputs, valid_o drive registered values directly.

Reset
REQ-028 On rst_i high at edge: all registered fields 0, valid_o=0, ctrl_o=0.
REQ-029 Reset mid-stall or mid-flush: reset wins; outputs 0 next cycle.
REQ-030 After reset with all forward RegWrite inputs low, data1_o=data2_o=store_data_o=0.

Configuration
REQ-031 Macro ID_EX_FORWARD_EN: defined -> REQ-022..025 forwarding active.
REQ-032 Undefined -> forwarded A/B equal registered RS1data/RS2data; EX/MEM and MEM/WB inputs ignored, ports remain.

Structure
REQ-033 Shared package holds DATA_W default, ctrl bit positions (CTRL_REGWRITE=3, CTRL_MEMTOREG=2, CTRL_MEMREAD=1, CTRL_MEMWRITE=0), forward-select encoding (FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2).
REQ-034 One sub-module fwd_sel: combinational select for one operand, instantiated twice.

Verification
REQ-035 Load RS1data=5, RS2data=7, ALUSrc=0, no hazards -> next cycle data1_o=5, data2_o=7, valid_o=1.
REQ-036 Registered RS1addr=3, EXMEM RD=3 RegWrite=1 data=0x10, MEMWB RD=3 RegWrite=1 data=0x20 -> data1_o=0x10.
REQ-037 RS2addr=0, EXMEM RD=0 RegWrite=1 data=0xFF, RS2data=0 -> store_data_o=0.
REQ-038 ALUSrc=1, imm=0xFFFFFFFC, RS2addr matched by MEMWB data=9 -> data2_o=0xFFFFFFFC, store_data_o=9.
REQ-039 stall_i=1 for 3 cycles with new inputs -> registered outputs unchanged; then flush_i=1 with stall_i=1 -> ctrl_o=0, valid_o=0.
REQ-040 rst_i=1 while stall_i=1 and valid_o=1 -> next cycle all outputs 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
//==============================================================================
// Module  : id_ex_stage_pkg
// Brief   : Shared widths, control-bit positions and forward-select encoding
//           for the ID/EX pipeline register.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int DATA_W_DEFAULT = 32;

  // Bit positions inside the 4-bit control bundle
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_sel.sv
//==============================================================================
// Module  : id_ex_stage_fwd_sel
// Brief   : Combinational operand forwarding select for one source register.
//           Forwarding only when ID_EX_FORWARD_EN is defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_stage_fwd_sel
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [4:0]        rs_addr_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exmem_regwrite_i,
  input  logic [4:0]        exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_regwrite_i,
  input  logic [4:0]        memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] operand_o
);

  fwd_sel_e w_sel;

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is younger than MEM/WB, so it is checked first; x0 never forwards
  always_comb begin
    w_sel = FWD_REG;
    if (exmem_regwrite_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == rs_addr_i))
      w_sel = FWD_EXMEM;
    else if (memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs_addr_i))
      w_sel = FWD_MEMWB;
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{rs_addr_i, exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                          memwb_regwrite_i, memwb_rd_i, memwb_data_i};
  assign w_sel = FWD_REG;
`endif

  always_comb begin
    operand_o = reg_data_i;
    case (w_sel)
      FWD_EXMEM: operand_o = exmem_data_i;
      FWD_MEMWB: operand_o = memwb_data_i;
      default:   operand_o = reg_data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//==============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with stall, flush and optional operand
//           forwarding (macro ID_EX_FORWARD_EN).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              ALUSrc_i,
  input  logic [2:0]        ALUCtrl_i,
  input  logic [3:0]        ctrl_i,
  input  logic [4:0]        RS1addr_i,
  input  logic [4:0]        RS2addr_i,
  input  logic [4:0]        RDaddr_i,
  input  logic              EXMEM_RegWrite_i,
  input  logic [4:0]        EXMEM_RDaddr_i,
  input  logic [DATA_W-1:0] EXMEM_data_i,
  input  logic              MEMWB_RegWrite_i,
  input  logic [4:0]        MEMWB_RDaddr_i,
  input  logic [DATA_W-1:0] MEMWB_data_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [2:0]        ALUCtrl_o,
  output logic [3:0]        ctrl_o,
  output logic [4:0]        RDaddr_o,
  output logic [4:0]        RS1addr_o,
  output logic [4:0]        RS2addr_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_alu_src;
  logic [2:0]        r_alu_ctrl;
  logic [3:0]        r_ctrl;
  logic [4:0]        r_rs1_addr;
  logic [4:0]        r_rs2_addr;
  logic [4:0]        r_rd_addr;
  logic              r_valid;

  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  // Flush loads a full bubble; stall only matters when neither reset nor flush
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_alu_src  <= 1'b0;
      r_alu_ctrl <= 3'd0;
      r_ctrl     <= 4'd0;
      r_rs1_addr <= 5'd0;
      r_rs2_addr <= 5'd0;
      r_rd_addr  <= 5'd0;
      r_valid    <= 1'b0;
    end else if (!stall_i) begin
      r_rs1_data <= RS1data_i;
      r_rs2_data <= RS2data_i;
      r_imm      <= imm_i;
      r_alu_src  <= ALUSrc_i;
      r_alu_ctrl <= ALUCtrl_i;
      r_ctrl     <= ctrl_i;
      r_rs1_addr <= RS1addr_i;
      r_rs2_addr <= RS2addr_i;
      r_rd_addr  <= RDaddr_i;
      r_valid    <= 1'b1;
    end
  end

  id_ex_stage_fwd_sel #(.DATA_W(DATA_W)) u_fwd_sel_a (
    .rs_addr_i        (r_rs1_addr),
    .reg_data_i       (r_rs1_data),
    .exmem_regwrite_i (EXMEM_RegWrite_i),
    .exmem_rd_i       (EXMEM_RDaddr_i),
    .exmem_data_i     (EXMEM_data_i),
    .memwb_regwrite_i (MEMWB_RegWrite_i),
    .memwb_rd_i       (MEMWB_RDaddr_i),
    .memwb_data_i     (MEMWB_data_i),
    .operand_o        (w_fwd_a)
  );

  id_ex_stage_fwd_sel #(.DATA_W(DATA_W)) u_fwd_sel_b (
    .rs_addr_i        (r_rs2_addr),
    .reg_data_i       (r_rs2_data),
    .exmem_regwrite_i (EXMEM_RegWrite_i),
    .exmem_rd_i       (EXMEM_RDaddr_i),
    .exmem_data_i     (EXMEM_data_i),
    .memwb_regwrite_i (MEMWB_RegWrite_i),
    .memwb_rd_i       (MEMWB_RDaddr_i),
    .memwb_data_i     (MEMWB_data_i),
    .operand_o        (w_fwd_b)
  );

  assign data1_o      = w_fwd_a;
  assign store_data_o = w_fwd_b;
  assign data2_o      = r_alu_src ? r_imm : w_fwd_b;
  assign ALUCtrl_o    = r_alu_ctrl;
  assign ctrl_o       = r_ctrl;
  assign RDaddr_o     = r_rd_addr;
  assign RS1addr_o    = r_rs1_addr;
  assign RS2addr_o    = r_rs2_addr;
  assign valid_o      = r_valid;

endmodule

`default_nettype wire
